// File: rtl/lgn_seq_if.sv
// Byte-stream, network and result bus of lgn_frame_sequencer.
// master = stimulus/network side, slave = sequencer.
interface lgn_seq_if #(
    parameter int IMG_BITS    = 256,
    parameter int NUM_CLASSES = 10,
    parameter int CNT_W       = 8
);
    logic [7:0]                   in_data;
    logic                         in_valid;
    logic                         in_ready;
    logic [IMG_BITS-1:0]          img_bits;
    logic [NUM_CLASSES*CNT_W-1:0] class_cnt;
    logic [3:0]                   result;
    logic                         result_valid;
    logic                         busy;

    modport master (
        output in_data, in_valid, class_cnt,
        input  in_ready, img_bits, result, result_valid, busy
    );

    modport slave (
        input  in_data, in_valid, class_cnt,
        output in_ready, img_bits, result, result_valid, busy
    );
endinterface

// File: rtl/lgn_frame_sequencer.sv
// Frame sequencer for the LGN MNIST classifier: byte-wise image load, latency wait, argmax.
// Define LGN_SEQ_FAST_ARGMAX_EN for a single-cycle combinational argmax.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | no frame in progress, waiting for the first byte
// S_LOAD   | collecting image bytes
// S_WAIT   | image stable, waiting out the network pipeline latency
// S_ARGMAX | reducing per-class counts to the winning class
// S_DONE   | result presented; a new frame may start immediately
module lgn_frame_sequencer #(
    parameter int IMG_BITS    = 256,
    parameter int NET_LATENCY = 4,
    parameter int NUM_CLASSES = 10,
    parameter int CNT_W       = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      ena,
    lgn_seq_if.slave  bus
);
    localparam int NUM_BYTES = IMG_BITS / 8;
    localparam int BC_W      = $clog2(NUM_BYTES + 1);
    localparam int WC_W      = (NET_LATENCY > 1) ? $clog2(NET_LATENCY) : 1;
    localparam int IDX_W     = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

    localparam logic [BC_W-1:0] BYTES_FULL = BC_W'(NUM_BYTES);
    localparam logic [WC_W-1:0] WAIT_LAST  = WC_W'(NET_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_ARGMAX,
        S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [IMG_BITS-1:0] img_q, img_nxt;
    logic [BC_W-1:0]     byte_cnt, byte_cnt_nxt, byte_cnt_inc;
    logic [WC_W-1:0]     wait_cnt, wait_cnt_nxt;
    logic [3:0]          result_q, result_nxt;
    logic                rv_q, rv_nxt;
    logic                in_ready;
    logic                accept;
    logic [CNT_W-1:0]    cnt_arr [NUM_CLASSES];

`ifdef LGN_SEQ_FAST_ARGMAX_EN
    logic [IDX_W-1:0]    fast_idx;
    logic [CNT_W-1:0]    fast_cnt;
`else
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CLASSES - 1);

    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [IDX_W-1:0]    best_idx, best_idx_nxt;
    logic [CNT_W-1:0]    best_cnt, best_cnt_nxt;
    logic [CNT_W-1:0]    cur_cnt;
`endif

    always_comb begin
        for (int k = 0; k < NUM_CLASSES; k++) begin
            cnt_arr[k] = bus.class_cnt[k*CNT_W +: CNT_W];
        end
    end

`ifdef LGN_SEQ_FAST_ARGMAX_EN
    // Strictly-greater scan from class 0 upward keeps the lowest index on ties.
    always_comb begin
        fast_idx = '0;
        fast_cnt = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (cnt_arr[k] > fast_cnt) begin
                fast_cnt = cnt_arr[k];
                fast_idx = IDX_W'(k);
            end
        end
    end
`else
    assign cur_cnt = cnt_arr[idx];
`endif

    // rst_n gates in_ready directly since the synchronous reset has not yet taken effect.
    assign in_ready = rst_n && ena &&
                      ((state == S_IDLE) || (state == S_LOAD) || (state == S_DONE));
    assign accept   = in_ready && bus.in_valid;

    always_comb begin
        state_nxt    = state;
        img_nxt      = img_q;
        byte_cnt_nxt = byte_cnt;
        wait_cnt_nxt = wait_cnt;
        result_nxt   = result_q;
        rv_nxt       = rv_q;
        byte_cnt_inc = (state == S_LOAD) ? (byte_cnt + BC_W'(1)) : BC_W'(1);
`ifndef LGN_SEQ_FAST_ARGMAX_EN
        idx_nxt      = idx;
        best_idx_nxt = best_idx;
        best_cnt_nxt = best_cnt;
`endif
        if (ena) begin
            case (state)
                S_IDLE, S_LOAD, S_DONE: begin
                    if (accept) begin
                        img_nxt = (img_q << 8) | IMG_BITS'(bus.in_data);
                        rv_nxt  = 1'b0;
                        if (byte_cnt_inc == BYTES_FULL) begin
                            state_nxt    = S_WAIT;
                            byte_cnt_nxt = '0;
                            wait_cnt_nxt = '0;
                        end else begin
                            state_nxt    = S_LOAD;
                            byte_cnt_nxt = byte_cnt_inc;
                        end
                    end
                end
                S_WAIT: begin
                    wait_cnt_nxt = wait_cnt + WC_W'(1);
                    if (wait_cnt == WAIT_LAST) begin
                        state_nxt = S_ARGMAX;
`ifndef LGN_SEQ_FAST_ARGMAX_EN
                        idx_nxt      = '0;
                        best_idx_nxt = '0;
                        best_cnt_nxt = '0;
`endif
                    end
                end
                S_ARGMAX: begin
`ifdef LGN_SEQ_FAST_ARGMAX_EN
                    result_nxt = 4'(fast_idx);
                    rv_nxt     = 1'b1;
                    state_nxt  = S_DONE;
`else
                    if (cur_cnt > best_cnt) begin
                        best_cnt_nxt = cur_cnt;
                        best_idx_nxt = idx;
                    end
                    idx_nxt = idx + IDX_W'(1);
                    if (idx == IDX_LAST) begin
                        result_nxt = 4'((cur_cnt > best_cnt) ? idx : best_idx);
                        rv_nxt     = 1'b1;
                        state_nxt  = S_DONE;
                    end
`endif
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            img_q    <= '0;
            byte_cnt <= '0;
            wait_cnt <= '0;
            result_q <= '0;
            rv_q     <= 1'b0;
`ifndef LGN_SEQ_FAST_ARGMAX_EN
            idx      <= '0;
            best_idx <= '0;
            best_cnt <= '0;
`endif
        end else begin
            state    <= state_nxt;
            img_q    <= img_nxt;
            byte_cnt <= byte_cnt_nxt;
            wait_cnt <= wait_cnt_nxt;
            result_q <= result_nxt;
            rv_q     <= rv_nxt;
`ifndef LGN_SEQ_FAST_ARGMAX_EN
            idx      <= idx_nxt;
            best_idx <= best_idx_nxt;
            best_cnt <= best_cnt_nxt;
`endif
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.img_bits     = img_q;
    assign bus.result       = result_q;
    assign bus.result_valid = rv_q;
    assign bus.busy         = (state == S_WAIT) || (state == S_ARGMAX);

endmodule

// File: doc/lgn_frame_sequencer.md
# lgn_frame_sequencer

Sequences one inference of the logic-gate-network MNIST classifier inside `tt_um_rejunity_lgn_mnist`. It assembles a binarized image from a byte stream on the dedicated inputs and holds it stable on the network inputs. It waits out the network's pipeline latency, then reduces the per-class popcounts to a single argmax class. The result is presented to the output pins with a valid flag.

## Interface
- `IMG_BITS`, 256 — image size in bits; must be a multiple of 8.
- `NET_LATENCY`, 4 — cycles from a stable `img_bits` to valid `class_cnt`; must be ≥1.
- `NUM_CLASSES`, 10 — number of classes; must be ≤16.
- `CNT_W`, 8 — popcount width per class.

- `clk` in 1 — single clock.
- `rst_n` in 1 — synchronous, active-low reset.
- `ena` in 1 — when low, all state, counters and registers are frozen and `in_ready` is 0.
- `in_data` in 8 — image byte.
- `in_valid` in 1 — `in_data` valid.
- `in_ready` out 1 — byte accepted on an edge where `in_valid && in_ready`.
- `img_bits` out IMG_BITS — registered image to the network.
- `class_cnt` in NUM_CLASSES*CNT_W — class k count at `[k*CNT_W +: CNT_W]`, unsigned.
- `result` out 4 — argmax class index.
- `result_valid` out 1 — `result` valid.
- `busy` out 1 — high in WAIT or ARGMAX.

## Operation
- States: IDLE, LOAD, WAIT, ARGMAX, DONE.
- `in_ready = ena` in IDLE, LOAD and DONE; 0 in WAIT and ARGMAX.
- **Byte acceptance:**
  - `img_bits` shifts left by 8 with `in_data` entering the LSBs.
  - The first byte of a frame ends up in `img_bits[IMG_BITS-1 -: 8]`.
  - `byte_cnt` increments on each accepted byte.
- **IDLE or DONE + accept:** `byte_cnt` is set to 1, `result_valid` is cleared, and the state goes to LOAD. In DONE, `result` keeps its old value until it is overwritten.
- **LOAD + accept with `byte_cnt == IMG_BITS/8-1`:**
  - State goes to WAIT, `wait_cnt` is set to 0 and `byte_cnt` to 0.
  - If IMG_BITS == 8, IDLE goes directly to WAIT.
- **WAIT:**
  - `wait_cnt` increments each cycle.
  - When `wait_cnt == NET_LATENCY-1`, the state goes to ARGMAX with `idx` = 0, `best_idx` = 0 and `best_cnt` = 0.
- **ARGMAX (sequential):**
  - Each cycle compares `class_cnt[idx]` with `best_cnt`.
  - On strictly greater, `best_cnt` and `best_idx` are updated, so ties keep the lowest index.
  - At `idx == NUM_CLASSES-1`, `result` takes the final best index, `result_valid` is set to 1, and the state goes to DONE.
  - All-zero counts give `result` = 0.
- `img_bits` is unchanged from the last accepted byte through DONE, so `class_cnt` is stable during ARGMAX.
- `in_valid` is ignored while `in_ready` is 0. No bytes are dropped or buffered.
- **Reset:**
  - State is IDLE; all counters are 0.
  - `img_bits`, `result`, `result_valid` and `busy` are 0.
  - `in_ready` is 0 while `rst_n` is low and equals `ena` afterwards.
- Reset in mid-frame or mid-ARGMAX discards the partial frame, with no output glitch beyond the reset values.

## Timing
- Edge E accepts the last byte. Then:
  - `busy` rises after E.
  - ARGMAX is entered NET_LATENCY edges after E.
  - `result_valid` rises NET_LATENCY+NUM_CLASSES edges after E (14 with the defaults).
- In the fast variant, `result_valid` rises NET_LATENCY+1 edges after E.
- `busy` falls on the same edge that `result_valid` rises.
- A minimum-gap frame takes IMG_BITS/8 accept cycles plus the result latency. A back-to-back frame may begin in the first DONE cycle.
- `ena` low for N cycles stretches every latency by exactly N.

## Configuration
- `LGN_SEQ_FAST_ARGMAX_EN`:
  - When defined, ARGMAX is a single-cycle combinational reduction over all classes with the same lowest-index tie rule. The state exits to DONE after one cycle.
  - When undefined, the sequential reduction takes NUM_CLASSES cycles.
- `result` must be identical in both builds.

## Test plan
- **Reset:** hold `rst_n` low 3 cycles with `in_valid` = 1. Required: `result_valid` = 0, `img_bits` = 0, `busy` = 0, and no byte accepted.
- **Load order:** send bytes 0x00…0x1F with no gaps. Required: `img_bits[255:248]` = 0x00 and `img_bits[7:0]` = 0x1F, `busy` rises after byte 31, and `in_ready` drops.
- **Latency:** model counts = {class 7: 200, all others 10}. Required: `result` = 7, with `result_valid` rising exactly 14 edges after the last accept (5 with `LGN_SEQ_FAST_ARGMAX_EN`).
- **Tie and zero:** classes 3 and 8 both at 255 → `result` = 3. All counts 0 → `result` = 0.
- **Stall:** drop `in_valid` for 5 cycles mid-frame and `ena` for 3 cycles during WAIT. Required: the image is still correct and `result_valid` arrives exactly 3 cycles later than in the unstalled case.
- **Abort and restart:** assert `rst_n` low at byte 12. Required: all outputs return to reset values. A subsequent full frame produces the correct result, and a second frame sent during DONE clears `result_valid` on its first accepted byte.
